// File: rtl/dec_grant_arb_pkg.sv
// Shared definitions for the decoder-sharing round-robin arbiter.
package dec_grant_arb_pkg;

    localparam int NUM_REQ = 4;

    // The encodings are fixed so other tools can read the state bits directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [NUM_REQ-1:0] GNT_NONE = 4'b1111;

    // Active-low 2-to-4 decode with blanking. This is what the external decoder drives.
    function automatic logic [NUM_REQ-1:0] decode_sel(input logic [1:0] sel, input logic blank);
        return blank ? GNT_NONE : ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/dec_grant_arb_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface dec_grant_arb_if;
    import dec_grant_arb_pkg::*;

    logic                en;
    logic [NUM_REQ-1:0]  req;
    logic [1:0]          dec_sel;
    logic                dec_en;
    logic [NUM_REQ-1:0]  gnt_n;
    logic                busy;

    // The requester side drives enable and requests and observes the grant.
    modport master (
        output en, req,
        input  dec_sel, dec_en, gnt_n, busy
    );

    // The arbiter side consumes requests and drives the decoder controls.
    modport slave (
        input  en, req,
        output dec_sel, dec_en, gnt_n, busy
    );

endinterface

// File: rtl/dec_grant_arb_rr_pick4.sv
// Combinational rotated-priority pick among four requests.
module rr_pick4
    import dec_grant_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [1:0]         win_o,
    output logic               any_o
);

    logic [1:0] idx;
    logic       found;

    // Scan last+1 .. last+4 (wrapping) and keep the first requester found.
    always_comb begin
        win_o = last_i;
        any_o = |req_i;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_i + 2'(k);
            if (!found && req_i[idx]) begin
                win_o = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_grant_arb.sv
// Round-robin arbiter sharing one active-low select decoder among four requesters.
module dec_grant_arb
    import dec_grant_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            reset,
    dec_grant_arb_if.slave  bus
);

    state_t              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d;
    logic                dec_en_q, dec_en_d;
    logic [NUM_REQ-1:0]  gnt_n_q, gnt_n_d;
    logic                busy_q, busy_d;

    logic [1:0]          win;
    logic                anyReq;

    rr_pick4 u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (anyReq)
    );

    // Next state, pointer and counter; outputs are precomputed from the next state so they can be registered.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                if (bus.en && anyReq) begin
                    state_d = ST_GRANT;
                    last_d  = win;
                    cnt_d   = '0;
                    sel_d   = win;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CW'(1);
                if (!bus.en || !bus.req[last_q] || (cnt_q == CW'(HOLD_MAX - 1))) begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        dec_en_d = (state_d != ST_GRANT);
        gnt_n_d  = decode_sel(sel_d, dec_en_d);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset; last resets to 3 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            sel_q    <= 2'b00;
            dec_en_q <= 1'b1;
            gnt_n_q  <= GNT_NONE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            dec_en_q <= dec_en_d;
            gnt_n_q  <= gnt_n_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.dec_sel = sel_q;
    assign bus.dec_en  = dec_en_q;
    assign bus.gnt_n   = gnt_n_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dec_grant_arb.sv
// Randomized and directed bench for dec_grant_arb against a behavioural grant model.
module tb_dec_grant_arb;

    localparam int HOLD = 4;

    logic clk;
    logic reset;

    dec_grant_arb_if bus ();

    dec_grant_arb #(.HOLD_MAX(HOLD), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model: who owns the decoder now, how long they have held it, and who was served last.
    int mOwner;
    int mPtr;
    int mHeld;
    int mSel;
    bit mGap;
    int grantLog[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic enable, input logic [3:0] request);
        reset   = rst;
        bus.en  = enable;
        bus.req = request;
    endtask

    function automatic int pickWinner(input int ptr, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelStep();
        if (reset) begin
            mOwner = -1;
            mGap   = 1'b0;
            mPtr   = 3;
            mHeld  = 0;
            mSel   = 0;
        end else if (mOwner >= 0) begin
            mHeld++;
            if (!bus.en || !bus.req[mOwner] || mHeld >= HOLD) begin
                mOwner = -1;
                mGap   = 1'b1;
            end
        end else begin
            mGap = 1'b0;
            if (bus.en && bus.req != 4'b0000) begin
                mOwner = pickWinner(mPtr, bus.req);
                mPtr   = mOwner;
                mSel   = mOwner;
                mHeld  = 0;
                grantLog.push_back(mOwner);
            end
        end
    endtask

    task automatic compareAll();
        logic [3:0] expGnt;
        expGnt = (mOwner >= 0) ? ~(4'b0001 << mOwner) : 4'b1111;
        checkOutput("gnt_n",   8'(bus.gnt_n),   8'(expGnt));
        checkOutput("dec_en",  8'(bus.dec_en),  8'(mOwner < 0));
        checkOutput("dec_sel", 8'(bus.dec_sel), 8'(mSel));
        checkOutput("busy",    8'(bus.busy),    8'((mOwner >= 0) || mGap));
    endtask

    task automatic runCycle(input logic rst, input logic enable, input logic [3:0] request);
        applyStimulus(rst, enable, request);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic checkLog(input string tag, input int idx, input int expected);
        logic [7:0] seen;
        seen = (idx < grantLog.size()) ? 8'(grantLog[idx]) : 8'hFF;
        checkOutput(tag, seen, 8'(expected));
    endtask

    initial begin
        logic [3:0] r;
        logic       e;
        logic       rs;

        applyStimulus(1'b1, 1'b1, 4'b1111);

        // Reset held two cycles with everyone requesting, then requester 0 first.
        grantLog.delete();
        runCycle(1'b1, 1'b1, 4'b1111);
        runCycle(1'b1, 1'b1, 4'b1111);
        checkOutput("rstGnt", 8'(bus.gnt_n), 8'h0F);
        runCycle(1'b0, 1'b1, 4'b1111);
        checkOutput("firstGrant", 8'(bus.gnt_n), 8'h0E);

        // Rotation: each owner drops its request on its second grant cycle.
        for (int i = 0; i < 14; i++) begin
            r = 4'b1111;
            if (mOwner >= 0 && mHeld == 1) r = 4'b1111 & ~(4'b0001 << mOwner);
            runCycle(1'b0, 1'b1, r);
        end
        checkLog("rot0", 0, 0);
        checkLog("rot1", 1, 1);
        checkLog("rot2", 2, 2);
        checkLog("rot3", 3, 3);
        checkLog("rot4", 4, 0);

        // Forced release alternates between two steady requesters.
        runCycle(1'b1, 1'b1, 4'b0101);
        grantLog.delete();
        for (int i = 0; i < 16; i++) runCycle(1'b0, 1'b1, 4'b0101);
        checkLog("hold0", 0, 0);
        checkLog("hold1", 1, 2);
        checkLog("hold2", 2, 0);

        // A sole requester is re-granted after its forced gap.
        runCycle(1'b1, 1'b1, 4'b1000);
        grantLog.delete();
        for (int i = 0; i < 12; i++) runCycle(1'b0, 1'b1, 4'b1000);
        checkLog("sole0", 0, 3);
        checkLog("sole1", 1, 3);
        checkOutput("soleSel", 8'(bus.dec_sel), 8'd3);

        // Enable drop while requester 1 owns the decoder.
        runCycle(1'b1, 1'b1, 4'b0010);
        runCycle(1'b0, 1'b1, 4'b0010);
        checkOutput("en1Gnt", 8'(bus.gnt_n), 8'h0D);
        runCycle(1'b0, 1'b0, 4'b0010);
        checkOutput("enGapGnt", 8'(bus.gnt_n), 8'h0F);
        checkOutput("enGapBusy", 8'(bus.busy), 8'd1);
        runCycle(1'b0, 1'b0, 4'b0010);
        checkOutput("enIdleBusy", 8'(bus.busy), 8'd0);
        runCycle(1'b0, 1'b1, 4'b0011);
        checkOutput("enWrap", 8'(bus.gnt_n), 8'h0E);

        // Reset while requester 2 owns the decoder restores the pointer.
        runCycle(1'b1, 1'b1, 4'b0100);
        runCycle(1'b0, 1'b1, 4'b0100);
        checkOutput("rmGnt", 8'(bus.gnt_n), 8'h0B);
        runCycle(1'b1, 1'b1, 4'b0100);
        checkOutput("rmDrop", 8'(bus.gnt_n), 8'h0F);
        runCycle(1'b0, 1'b1, 4'b0110);
        checkOutput("rmFirst", 8'(bus.gnt_n), 8'h0D);

        // Random traffic with occasional enable drops and resets.
        for (int i = 0; i < 600; i++) begin
            r  = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 59) == 0);
            if (mOwner >= 0 && $urandom_range(0, 3) != 0) r[mOwner] = 1'b1;
            runCycle(rs, e, r);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
